// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler that owns the register file write port.
// It arbitrates pipeline port A against long-latency port B, keeps the busy scoreboard and drives the issue stall.
module regfile_wb_scheduler #(
  parameter int Nloc         = 32,
  parameter int Dbits        = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    issue_valid,
  input  logic [$clog2(Nloc)-1:0] issue_rs,
  input  logic [$clog2(Nloc)-1:0] issue_rt,
  input  logic [$clog2(Nloc)-1:0] issue_rd,
  input  logic                    issue_long,
  output logic                    stall,
  input  logic                    a_wr,
  input  logic [$clog2(Nloc)-1:0] a_addr,
  input  logic [Dbits-1:0]        a_data,
  input  logic                    b_valid,
  input  logic [$clog2(Nloc)-1:0] b_addr,
  input  logic [Dbits-1:0]        b_data,
  output logic                    b_ready,
  output logic                    rf_wr,
  output logic [$clog2(Nloc)-1:0] rf_waddr,
  output logic [Dbits-1:0]        rf_wdata,
  output logic [Nloc-1:0]         busy_vec
);

  localparam int AW = $clog2(Nloc);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [Nloc-1:0] busy;
  logic [Nloc-1:0] busy_next;
  logic [CW-1:0]   starve_cnt;
  logic            b_xfer;
  logic            starve_hold;
  logic            hazard;
  logic            accept;

  // Port A always wins; B sees ready whenever A is idle, even without a request.
  always_comb begin
    rf_waddr = a_addr;
    rf_wdata = a_data;
    b_ready  = 1'b0;
    rf_wr    = 1'b0;
    if (!reset) begin
      if (a_wr) begin
        rf_wr = (a_addr != '0);
      end else begin
        b_ready = 1'b1;
        if (b_valid) begin
          rf_waddr = b_addr;
          rf_wdata = b_data;
          rf_wr    = (b_addr != '0);
        end
      end
    end
  end

  assign b_xfer      = b_valid & b_ready;
  assign starve_hold = (starve_cnt == LIMIT);

  assign hazard = issue_valid &
                  ((busy[issue_rs] & (issue_rs != '0)) |
                   (busy[issue_rt] & (issue_rt != '0)) |
                   (busy[issue_rd] & (issue_rd != '0)));

  assign stall    = reset | hazard | starve_hold;
  assign accept   = issue_valid & ~stall;
  assign busy_vec = busy;

  // Clear on B completion first so that a same-cycle set takes priority.
  always_comb begin
    busy_next = busy;
    if (b_xfer) begin
      busy_next[b_addr] = 1'b0;
    end
    if (accept && issue_long && (issue_rd != '0)) begin
      busy_next[issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (b_valid && !b_ready) begin
      if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + CW'(1);
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  logic unused_aw;
  assign unused_aw = (AW == 0);

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed self-checking bench for regfile_wb_scheduler.
// Inputs change just after each negedge; outputs are checked 1ns later.
module tb_regfile_wb_scheduler;

  logic        clock;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rs;
  logic [4:0]  issue_rt;
  logic [4:0]  issue_rd;
  logic        issue_long;
  logic        stall;
  logic        a_wr;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        b_valid;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        b_ready;
  logic        rf_wr;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy_vec;

  int checks = 0;
  int errors = 0;

  regfile_wb_scheduler #(.Nloc(32), .Dbits(32), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_rd(issue_rd), .issue_long(issue_long), .stall(stall),
    .a_wr(a_wr), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .rf_wr(rf_wr), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy_vec(busy_vec)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic applyStimulus(input logic iv, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic il,
                               input logic aw, input logic [4:0] aa, input logic [31:0] ad,
                               input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    issue_valid = iv; issue_rs = rs; issue_rt = rt; issue_rd = rd; issue_long = il;
    a_wr = aw; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle;
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();

    // Reset holds outputs quiet even with both ports requesting
    applyStimulus(1, 1, 2, 3, 1, 1, 3, 32'h11, 1, 7, 32'h77);
    checkOutput("rst_stall", {31'b0, stall}, 32'd1);
    checkOutput("rst_bready", {31'b0, b_ready}, 32'd0);
    checkOutput("rst_rfwr", {31'b0, rf_wr}, 32'd0);
    checkOutput("rst_busy", busy_vec, 32'h0);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();

    // Long op to r5, RAW stall, B completion
    applyStimulus(1, 1, 2, 5, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("long5_stall", {31'b0, stall}, 32'd0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("long5_busy", busy_vec, 32'h0000_0020);
    applyStimulus(1, 5, 0, 6, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("raw5_stall", {31'b0, stall}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF);
    checkOutput("b5_ready", {31'b0, b_ready}, 32'd1);
    checkOutput("b5_rfwr", {31'b0, rf_wr}, 32'd1);
    checkOutput("b5_waddr", {27'b0, rf_waddr}, 32'd5);
    checkOutput("b5_wdata", rf_wdata, 32'hDEADBEEF);
    nextCycle();
    applyStimulus(1, 5, 0, 6, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("b5_busy_clr", busy_vec, 32'h0);
    checkOutput("b5_stall_clr", {31'b0, stall}, 32'd0);

    // A beats B, then B goes when A drops
    applyStimulus(0, 0, 0, 0, 0, 1, 3, 32'h11, 1, 7, 32'h77);
    checkOutput("arb_waddr_a", {27'b0, rf_waddr}, 32'd3);
    checkOutput("arb_wdata_a", rf_wdata, 32'h11);
    checkOutput("arb_bready_a", {31'b0, b_ready}, 32'd0);
    checkOutput("arb_rfwr_a", {31'b0, rf_wr}, 32'd1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 3, 32'h11, 1, 7, 32'h77);
    checkOutput("arb_bready_b", {31'b0, b_ready}, 32'd1);
    checkOutput("arb_waddr_b", {27'b0, rf_waddr}, 32'd7);
    checkOutput("arb_wdata_b", rf_wdata, 32'h77);
    nextCycle();

    // Starvation: stall rises after exactly four refused cycles
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 1, 3, 32'h22, 1, 7, 32'h99);
      checkOutput($sformatf("starve_pre%0d", i), {31'b0, stall}, 32'd0);
      nextCycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 1, 3, 32'h22, 1, 7, 32'h99);
    checkOutput("starve_hold", {31'b0, stall}, 32'd1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 1, 3, 32'h22, 1, 7, 32'h99);
    checkOutput("starve_sat", {31'b0, stall}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 3, 32'h22, 1, 7, 32'h99);
    checkOutput("starve_bready", {31'b0, b_ready}, 32'd1);
    checkOutput("starve_waddr", {27'b0, rf_waddr}, 32'd7);
    nextCycle();
    applyStimulus(1, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("starve_release", {31'b0, stall}, 32'd0);

    // Register 0 writes are dropped, long rd=0 never marks busy
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'h55, 0, 0, 0);
    checkOutput("r0_a_rfwr", {31'b0, rf_wr}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h66);
    checkOutput("r0_b_bready", {31'b0, b_ready}, 32'd1);
    checkOutput("r0_b_rfwr", {31'b0, rf_wr}, 32'd0);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("r0_long_stall", {31'b0, stall}, 32'd0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("r0_long_busy", busy_vec, 32'h0);

    // WAW on r9, rt hazard, and all-zero operands never stall
    applyStimulus(1, 1, 2, 9, 1, 0, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(1, 1, 2, 9, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("waw9_busy", busy_vec, 32'h0000_0200);
    checkOutput("waw9_stall", {31'b0, stall}, 32'd1);
    applyStimulus(1, 1, 9, 4, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rt9_stall", {31'b0, stall}, 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("zero_ops_stall", {31'b0, stall}, 32'd0);

    // Build busy=0x120 and starve_cnt=2, then reset mid-cycle
    applyStimulus(1, 0, 0, 5, 1, 0, 0, 0, 1, 9, 32'h99);
    nextCycle();
    applyStimulus(1, 0, 0, 8, 1, 1, 3, 32'h33, 1, 4, 32'h44);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 1, 3, 32'h33, 1, 4, 32'h44);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 1, 3, 32'h33, 1, 4, 32'h44);
    checkOutput("pre_rst_busy", busy_vec, 32'h0000_0120);
    checkOutput("pre_rst_stall", {31'b0, stall}, 32'd0);
    #1 reset = 1'b1;
    #1;
    checkOutput("mid_rst_busy", busy_vec, 32'h0);
    checkOutput("mid_rst_stall", {31'b0, stall}, 32'd1);
    checkOutput("mid_rst_rfwr", {31'b0, rf_wr}, 32'd0);
    nextCycle();
    reset = 1'b0;
    applyStimulus(1, 5, 8, 1, 0, 0, 0, 0, 1, 5, 32'hCAFE);
    checkOutput("post_rst_stall", {31'b0, stall}, 32'd0);
    checkOutput("post_rst_bready", {31'b0, b_ready}, 32'd1);
    checkOutput("post_rst_rfwr", {31'b0, rf_wr}, 32'd1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("post_rst_busy", busy_vec, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Sits in front of register_file's single write port and owns it.
- Arbitrates between two writeback sources:
  - Port A: the in-order pipeline writeback. It cannot be back-pressured.
  - Port B: long-latency units (multiplier/divider, memory loads), using a valid/ready handshake.
- Holds a per-register scoreboard of outstanding long-latency destinations.
- Drives the issue stall for RAW/WAW hazards and for port B starvation relief.

Parameters:
- Nloc, 32, number of architectural registers (register 0 hardwired zero).
- Dbits, 32, data width.
- STARVE_LIMIT, 4, consecutive refused cycles of a pending B request before issue is stalled to free the write port (must be ≥1).

Ports:
- clock  input  1  system clock, all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- issue_valid  input  1  an instruction is presented at issue.
- issue_rs  input  $clog2(Nloc)  first source register.
- issue_rt  input  $clog2(Nloc)  second source register.
- issue_rd  input  $clog2(Nloc)  destination register.
- issue_long  input  1  instruction retires through port B.
- stall  output  1  issue must hold; instruction not accepted this cycle.
- a_wr  input  1  port A write request.
- a_addr  input  $clog2(Nloc)  port A destination.
- a_data  input  Dbits  port A data.
- b_valid  input  1  port B write request.
- b_addr  input  $clog2(Nloc)  port B destination.
- b_data  input  Dbits  port B data.
- b_ready  output  1  port B write accepted this cycle.
- rf_wr  output  1  to register_file wr.
- rf_waddr  output  $clog2(Nloc)  to register_file WriteAddr.
- rf_wdata  output  Dbits  to register_file WriteData.
- busy_vec  output  Nloc  scoreboard state (debug/verification visibility).

Behaviour:
- Clock is clock; reset is asynchronous, active-high, named reset.
- State:
  - busy[Nloc-1:0].
  - starve_cnt, $clog2(STARVE_LIMIT+1) bits, saturating at STARVE_LIMIT.
  - Both clear asynchronously on reset.
  - busy[0] is never set.
- While reset is high: stall=1, b_ready=0, rf_wr=0, busy_vec=0.

Write-port arbitration (combinational, zero latency; write lands at the same posedge as register_file):
- a_wr=1: A wins.
  - rf_waddr=a_addr, rf_wdata=a_data.
  - b_ready=0.
- a_wr=0 and b_valid=1: B wins.
  - b_ready=1, rf_waddr=b_addr, rf_wdata=b_data.
- Neither request: rf_wr=0, and rf_waddr/rf_wdata are don't-care (drive the A values).
- rf_wr = winner present AND winning address ≠ 0.
  - A write to register 0 is dropped.
  - The B handshake still completes (b_ready=1).
- b_ready=1 while b_valid=0 is permitted when a_wr=0. A transfer occurs only on b_valid & b_ready.

Starvation counter:
- b_valid & !b_ready: starve_cnt increments, saturating.
- Any B transfer, or b_valid=0: starve_cnt clears to 0 next edge.
- starve_hold = (starve_cnt == STARVE_LIMIT).

Scoreboard / stall:
- hazard = issue_valid & ((busy[issue_rs] & rs≠0) | (busy[issue_rt] & rt≠0) | (busy[issue_rd] & rd≠0)).
- stall = hazard | starve_hold. It is combinational and independent of whether issue_valid is high when starve_hold is set.
- Issue accepted = issue_valid & !stall.
- On accept with issue_long=1 and issue_rd≠0: busy[issue_rd] is set at the next edge.
- On a B transfer: busy[b_addr] is cleared at the next edge.
- Set and clear of the same bit in one cycle: set wins. This cannot arise from legal traffic because a busy rd stalls; it is defined only for robustness.
- A B transfer to a non-busy register still writes the register file.
- Port A writes never touch busy.
- Reset mid-operation: all pending busy bits are discarded. Outstanding B transfers after reset are accepted normally.

Test Plan:
- Reset, then issue long op rd=5 (issue_valid=1, issue_long=1) -> stall=0; next cycle busy_vec[5]=1. Issue rs=5 -> stall=1. B transfer b_addr=5, b_data=0xDEADBEEF with a_wr=0 -> rf_wr=1, rf_waddr=5. Next cycle busy_vec[5]=0, stall=0.
- a_wr=1 (addr 3, 0x11) and b_valid=1 (addr 7) in the same cycle -> rf_waddr=3, rf_wdata=0x11, b_ready=0. Next cycle a_wr=0 -> b_ready=1, rf_waddr=7.
- a_wr held 1 and b_valid held 1 with STARVE_LIMIT=4 -> stall rises after exactly 4 refused cycles. Drop a_wr -> B accepted. Next cycle starve_cnt=0 and stall=0 (absent hazard).
- Writes to register 0: a_wr=1 a_addr=0 -> rf_wr=0. b_valid=1 b_addr=0, a_wr=0 -> b_ready=1, rf_wr=0. Long issue with rd=0 -> busy_vec stays 0.
- WAW: busy[9]=1, issue non-long rd=9 -> stall=1. Issue rs=0, rt=0, rd=0 -> stall=0.
- Assert reset asynchronously mid-cycle with busy_vec=0x0000_0120 and starve_cnt=2 -> busy_vec=0 and stall=1 immediately. After release, stall=0 for a non-hazard issue.
